// File: rtl/mem_slice.sv
// rtl/mem_slice.sv - MEM stage of the 16-bit 5-stage CPU: EX/MEM reg, flags, branch resolve, dmem FSM, MEM/WB reg
//
// Purpose:
//   Sits directly after EX. Holds the EX/MEM pipeline register, the
//   architectural flag register, resolves branches against those flags,
//   runs the data-memory request/ready handshake and feeds the MEM/WB
//   register read by writeback. Stalls the front of the pipe while a
//   memory access waits for ready, and squashes younger work on a taken
//   branch.
//
// Optional build macro:
//   DMEM_TIMEOUT_EN - abort a memory access that has waited TIMEOUT cycles,
//                     complete it with read data 0 and set sticky mem_err.
//                     Without it an access waits forever and mem_err is 0.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   ex_valid, addr, data, result    EX stage instruction, address, store data, ALU result
//   flags, set_flags                {zr,neg,ov} from ALU and its update enable
//   PCbranch, bcond                 branch target and condition code
//   rd_in, WB, M                    dest reg, {RegWrite,MemToReg}, {Branch,MemRead,MemWrite}
//   dmem_req/we/addr/wdata          data memory request side
//   dmem_rdata, dmem_ready          data memory response side
//   stall                           freeze PC, IF/ID, ID/EX
//   take_branch, branch_target      PC redirect and squash
//   flag_q                          architectural flags
//   wb_valid, wb_rd, wb_ctl, wb_data MEM/WB register
//   mem_err                         sticky access-abort flag
module mem_slice #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] result,
  input  logic [2:0]        flags,
  input  logic              set_flags,
  input  logic [DATA_W-1:0] PCbranch,
  input  logic [2:0]        bcond,
  input  logic [3:0]        rd_in,
  input  logic [1:0]        WB,
  input  logic [2:0]        M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall,
  output logic              take_branch,
  output logic [DATA_W-1:0] branch_target,
  output logic [2:0]        flag_q,
  output logic              wb_valid,
  output logic [3:0]        wb_rd,
  output logic [1:0]        wb_ctl,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // EX/MEM register
  logic              em_valid;
  logic [DATA_W-1:0] em_addr;
  logic [DATA_W-1:0] em_data;
  logic [DATA_W-1:0] em_result;
  logic [DATA_W-1:0] em_PCbranch;
  logic [2:0]        em_bcond;
  logic [3:0]        em_rd;
  logic [1:0]        em_WB;
  logic [2:0]        em_M;

  logic [0:0]        state_q;
  logic              done_q;     // access in EX/MEM already finished by abort
  logic              mem_op;
  logic              cond_ok;
  logic [DATA_W-1:0] load_data;

  // Field aliases: em_M = {Branch,MemRead,MemWrite}, em_WB = {RegWrite,MemToReg}
  logic em_branch, em_mem_read, em_mem_write, em_mem_to_reg;
  assign em_branch     = em_M[2];
  assign em_mem_read   = em_M[1];
  assign em_mem_write  = em_M[0];
  assign em_mem_to_reg = em_WB[0];

  // flag_q = {zr,neg,ov}
  always_comb begin
    cond_ok = 1'b0;
    case (em_bcond)
      3'b000:  cond_ok = !flag_q[2];
      3'b001:  cond_ok = flag_q[2];
      3'b010:  cond_ok = !flag_q[2] && !flag_q[1];
      3'b011:  cond_ok = flag_q[1];
      3'b100:  cond_ok = flag_q[2] || !flag_q[1];
      3'b101:  cond_ok = flag_q[2] || flag_q[1];
      3'b110:  cond_ok = flag_q[0];
      default: cond_ok = 1'b1;
    endcase
  end

  assign take_branch   = em_valid && em_branch && cond_ok;
  assign branch_target = em_PCbranch;

  assign mem_op     = em_valid && (em_mem_read || em_mem_write);
  assign dmem_req   = mem_op && !done_q;
  assign dmem_we    = em_mem_write;
  assign dmem_addr  = em_addr;
  assign dmem_wdata = em_data;
  assign stall      = dmem_req && !dmem_ready;

  // An aborted access completes with zero read data.
  assign load_data = done_q ? '0 : dmem_rdata;

  // EX/MEM capture and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_valid    <= 1'b0;
      em_addr     <= '0;
      em_data     <= '0;
      em_result   <= '0;
      em_PCbranch <= '0;
      em_bcond    <= '0;
      em_rd       <= '0;
      em_WB       <= '0;
      em_M        <= '0;
      flag_q      <= '0;
    end else if (!stall) begin
      if (take_branch) begin
        em_valid <= 1'b0;
      end else begin
        em_valid    <= ex_valid;
        em_addr     <= addr;
        em_data     <= data;
        em_result   <= result;
        em_PCbranch <= PCbranch;
        em_bcond    <= bcond;
        em_rd       <= rd_in;
        em_WB       <= WB;
        em_M        <= M;
        if (ex_valid && set_flags)
          flag_q <= flags;
      end
    end
  end

  // MEM/WB capture; a stall inserts a bubble while the access waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_ctl   <= '0;
      wb_data  <= '0;
    end else if (stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= em_valid;
      wb_rd    <= em_rd;
      wb_ctl   <= em_WB;
      wb_data  <= em_mem_to_reg ? load_data : em_result;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       mem_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      // done_q only lives until the aborted instruction leaves EX/MEM
      if (!stall)
        done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (dmem_req && !dmem_ready)
            state_q <= ST_WAIT;
        end
        default: begin
          if (dmem_ready) begin
            state_q  <= ST_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            state_q   <= ST_IDLE;
            wait_cnt  <= '0;
            done_q    <= 1'b1;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign mem_err = mem_err_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (dmem_req && !dmem_ready) state_q <= ST_WAIT;
        default: if (dmem_ready) state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_q  = 1'b0;
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_slice.sv
// tb/tb_mem_slice.sv - directed self-checking bench for mem_slice
module tb_mem_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] addr, data, result, PCbranch, dmem_rdata;
  logic [2:0]  flags, bcond, M;
  logic        set_flags;
  logic [3:0]  rd_in;
  logic [1:0]  WB;
  logic        dmem_ready;
  logic        dmem_req, dmem_we, stall, take_branch, wb_valid, mem_err;
  logic [15:0] dmem_addr, dmem_wdata, branch_target, wb_data;
  logic [2:0]  flag_q;
  logic [3:0]  wb_rd;
  logic [1:0]  wb_ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_slice #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .addr(addr), .data(data),
    .result(result), .flags(flags), .set_flags(set_flags), .PCbranch(PCbranch),
    .bcond(bcond), .rd_in(rd_in), .WB(WB), .M(M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall(stall), .take_branch(take_branch), .branch_target(branch_target),
    .flag_q(flag_q), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ctl(wb_ctl),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; set_flags = 0; flags = 0; M = 0; WB = 0; bcond = 0;
    rd_in = 0; addr = 0; data = 0; result = 0; PCbranch = 0;
  endtask

  task automatic ex_issue(input logic [2:0] m, input logic [1:0] wb, input logic [3:0] rd,
                          input logic [15:0] a, input logic [15:0] d, input logic [15:0] r,
                          input logic sf, input logic [2:0] fl, input logic [2:0] bc,
                          input logic [15:0] pcb);
    ex_valid = 1; M = m; WB = wb; rd_in = rd; addr = a; data = d; result = r;
    set_flags = sf; flags = fl; bcond = bc; PCbranch = pcb;
  endtask

  int n;

  initial begin
    rst = 1; dmem_ready = 0; dmem_rdata = 0;
    ex_idle();
    tick(); tick();
    check("rst_wb_valid", 16'(wb_valid), 16'd0);
    check("rst_flag_q", 16'(flag_q), 16'd0);
    check("rst_req", 16'(dmem_req), 16'd0);
    check("rst_mem_err", 16'(mem_err), 16'd0);
    rst = 0;

    // ADD sets flags zr=1, then BEQ taken
    ex_issue(3'b000, 2'b10, 4'd1, 0, 0, 16'h0001, 1, 3'b100, 3'b000, 0);
    tick();
    check("add_flag_q", 16'(flag_q), 16'h0004);
    ex_issue(3'b100, 2'b00, 4'd0, 0, 0, 0, 0, 3'b000, 3'b001, 16'h0040);
    tick();
    check("beq_take", 16'(take_branch), 16'd1);
    check("beq_target", branch_target, 16'h0040);
    check("add_wb_data", wb_data, 16'h0001);
    check("add_wb_rd", 16'(wb_rd), 16'd1);
    // younger instruction must be squashed, its flags ignored
    ex_issue(3'b000, 2'b10, 4'd2, 0, 0, 16'h0007, 1, 3'b000, 3'b000, 0);
    tick();
    check("squash_take", 16'(take_branch), 16'd0);
    check("beq_wb_valid", 16'(wb_valid), 16'd1);
    check("beq_wb_ctl", 16'(wb_ctl), 16'd0);
    check("squash_flags", 16'(flag_q), 16'h0004);
    ex_idle();
    tick();
    check("bubble_wb_valid", 16'(wb_valid), 16'd0);

    // BLT with neg=0 not taken, then ADD 5
    ex_issue(3'b100, 2'b00, 4'd0, 0, 0, 0, 0, 3'b000, 3'b011, 16'h0080);
    tick();
    check("blt_take", 16'(take_branch), 16'd0);
    ex_issue(3'b000, 2'b10, 4'd3, 0, 0, 16'h0005, 0, 3'b000, 3'b000, 0);
    tick();
    ex_idle();
    tick();
    check("add5_wb_valid", 16'(wb_valid), 16'd1);
    check("add5_wb_data", wb_data, 16'h0005);
    check("add5_wb_rd", 16'(wb_rd), 16'd3);

    // Load with three wait cycles
    ex_issue(3'b010, 2'b11, 4'd4, 16'h0010, 0, 16'h1234, 0, 3'b000, 3'b000, 0);
    tick();
    ex_idle();
    check("ld_addr", dmem_addr, 16'h0010);
    check("ld_we", 16'(dmem_we), 16'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall) n++;
      tick();
    end
    check("ld_wait_wb_valid", 16'(wb_valid), 16'd0);
    dmem_ready = 1; dmem_rdata = 16'hBEEF;
    #1;
    check("ld_stall_cycles", 16'(n), 16'd3);
    check("ld_ready_stall", 16'(stall), 16'd0);
    tick();
    dmem_rdata = 16'h0000;
    check("ld_wb_valid", 16'(wb_valid), 16'd1);
    check("ld_wb_data", wb_data, 16'hBEEF);
    check("ld_wb_ctl", 16'(wb_ctl), 16'h0003);
    // stray ready with no request
    check("stray_req", 16'(dmem_req), 16'd0);
    check("stray_stall", 16'(stall), 16'd0);

    // Back-to-back zero-wait stores
    ex_issue(3'b001, 2'b00, 4'd0, 16'h0020, 16'h1111, 0, 0, 3'b000, 3'b000, 0);
    tick();
    ex_issue(3'b001, 2'b00, 4'd0, 16'h0021, 16'h2222, 0, 0, 3'b000, 3'b000, 0);
    check("st1_req", 16'(dmem_req & dmem_we), 16'd1);
    check("st1_wdata", dmem_wdata, 16'h1111);
    check("st1_stall", 16'(stall), 16'd0);
    tick();
    ex_idle();
    check("st2_req", 16'(dmem_req & dmem_we), 16'd1);
    check("st2_addr", dmem_addr, 16'h0021);
    check("st2_wdata", dmem_wdata, 16'h2222);
    check("st2_stall", 16'(stall), 16'd0);
    tick();
    check("st_done_req", 16'(dmem_req), 16'd0);
    dmem_ready = 0;

`ifdef DMEM_TIMEOUT_EN
    // Load never answered: 1 IDLE + 4 WAIT cycles of request, then abort
    ex_issue(3'b010, 2'b11, 4'd5, 16'h0030, 0, 16'h5555, 0, 3'b000, 3'b000, 0);
    tick();
    ex_idle();
    dmem_rdata = 16'hDEAD;
    n = 0;
    for (int i = 0; i < 20 && dmem_req; i++) begin
      n++;
      tick();
    end
    check("to_req_cycles", 16'(n), 16'd5);
    check("to_mem_err", 16'(mem_err), 16'd1);
    tick();
    check("to_wb_valid", 16'(wb_valid), 16'd1);
    check("to_wb_data", wb_data, 16'h0000);
    tick(); tick();
    check("to_mem_err_sticky", 16'(mem_err), 16'd1);
    dmem_rdata = 0;
`endif

    // Reset mid-WAIT
    ex_issue(3'b000, 2'b10, 4'd6, 0, 0, 16'h0009, 1, 3'b011, 3'b000, 0);
    tick();
    ex_issue(3'b010, 2'b11, 4'd7, 16'h0044, 0, 0, 0, 3'b000, 3'b000, 0);
    tick();
    ex_idle();
    tick();
    check("mw_req_before", 16'(dmem_req), 16'd1);
    check("mw_flag_before", 16'(flag_q), 16'h0003);
    rst = 1;
    #1;
    check("mw_req", 16'(dmem_req), 16'd0);
    check("mw_stall", 16'(stall), 16'd0);
    check("mw_flag_q", 16'(flag_q), 16'd0);
    check("mw_wb_valid", 16'(wb_valid), 16'd0);
    check("mw_wb_data", wb_data, 16'd0);
    check("mw_wb_rd", 16'(wb_rd), 16'd0);
    check("mw_wb_ctl", 16'(wb_ctl), 16'd0);
    check("mw_mem_err", 16'(mem_err), 16'd0);
    tick();
    rst = 0;
    tick();
    check("mw_post_req", 16'(dmem_req), 16'd0);
    check("mw_post_wb_valid", 16'(wb_valid), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
